// File: rtl/jtdd_mcu_bridge_if.sv
// jtdd_mcu_bridge_if: main CPU and MCU signals of the communication bridge
interface jtdd_mcu_bridge_if #(
    parameter int AW = 9
);
    logic          main_cen;
    logic          com_cs;
    logic [AW-1:0] main_addr;
    logic          main_rnw;
    logic [7:0]    main_din;
    logic [7:0]    mcu_ram;
    logic          mcu_halt;
    logic          mcu_nmi_set;
    logic          mcu_cen;
    logic          mcu_cs;
    logic [AW-1:0] mcu_addr;
    logic          mcu_we;
    logic [7:0]    mcu_din;
    logic [7:0]    mcu_dout;
    logic          mcu_wait;
    logic          mcu_nmi;
    logic          mcu_nmi_ack;
    logic          mcu_irq_req;
    logic          mcu_irqmain;
    logic          mcu_ban;
    logic          mcu_run;

    modport slave (
        input  main_cen, com_cs, main_addr, main_rnw, main_din,
        input  mcu_halt, mcu_nmi_set, mcu_cen, mcu_cs, mcu_addr, mcu_we, mcu_din,
        input  mcu_nmi_ack, mcu_irq_req,
        output mcu_ram, mcu_dout, mcu_wait, mcu_nmi, mcu_irqmain, mcu_ban, mcu_run
    );

    modport master (
        output main_cen, com_cs, main_addr, main_rnw, main_din,
        output mcu_halt, mcu_nmi_set, mcu_cen, mcu_cs, mcu_addr, mcu_we, mcu_din,
        output mcu_nmi_ack, mcu_irq_req,
        input  mcu_ram, mcu_dout, mcu_wait, mcu_nmi, mcu_irqmain, mcu_ban, mcu_run
    );
endinterface

// File: rtl/jtdd_mcu_bridge.sv
// jtdd_mcu_bridge: shared RAM, halt handshake, NMI latch and IRQ pulse between main CPU and MCU
module jtdd_mcu_bridge #(
    parameter int AW      = 9,
    parameter int IRQW    = 8,
    parameter int HALTLAT = 2
) (
    input logic              clk,
    input logic              rst_n,
    jtdd_mcu_bridge_if.slave bus
);
    localparam int HCW = $clog2(HALTLAT + 1);
    localparam int ICW = $clog2(IRQW + 1);

    typedef enum logic [1:0] {RUN, DRAIN, COUNT, HALTED} state_t;

    state_t         st, st_nx;
    logic [HCW-1:0] hcnt, hcnt_nx;
    logic [ICW-1:0] icnt;
    logic [7:0]     mem [0:2**AW-1];
    logic [7:0]     ram_q, dout_q;
    logic           pend, ban, nmi, halt_l, irq_l;
    logic           run, main_acc, main_wr, mcu_req, mcu_svc;
    logic [AW-1:0]  rd_addr;

    assign run      = st != HALTED;
    assign main_acc = bus.com_cs & bus.main_cen;
    assign main_wr  = main_acc & ~bus.main_rnw;
    assign mcu_req  = bus.mcu_cs & bus.mcu_cen & run;
    assign mcu_svc  = (mcu_req | pend) & ~main_acc;
    assign rd_addr  = main_acc ? bus.main_addr : bus.mcu_addr;

    assign bus.mcu_ram     = ram_q;
    assign bus.mcu_dout    = dout_q;
    assign bus.mcu_wait    = pend;
    assign bus.mcu_nmi     = nmi;
    assign bus.mcu_irqmain = icnt != '0;
    assign bus.mcu_ban     = ban;
    assign bus.mcu_run     = run;

    // RAM array: main writes take the single port first, a serviced MCU write otherwise
    always_ff @(posedge clk) begin
        if (main_wr) mem[bus.main_addr] <= bus.main_din;
        else if (mcu_svc & bus.mcu_we) mem[bus.mcu_addr] <= bus.mcu_din;
    end

    // Read data registers, stall flag, NMI latch, IRQ pulse counter and edge trackers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_q  <= 8'hFF;
            dout_q <= 8'hFF;
            pend   <= 1'b0;
            nmi    <= 1'b0;
            icnt   <= '0;
            irq_l  <= 1'b0;
            halt_l <= 1'b0;
            ban    <= 1'b0;
        end else begin
            ram_q  <= (main_acc & bus.main_rnw) ? mem[rd_addr] : ram_q;
            dout_q <= (mcu_svc & ~bus.mcu_we) ? mem[rd_addr] : dout_q;
            pend   <= (mcu_req | pend) & main_acc;
            nmi    <= bus.mcu_nmi_set | (nmi & ~bus.mcu_nmi_ack);
            icnt   <= (bus.mcu_irq_req & ~irq_l) ? ICW'(IRQW) : (icnt != '0) ? icnt - 1'b1 : icnt;
            irq_l  <= bus.mcu_irq_req;
            halt_l <= bus.mcu_halt;
            ban    <= (st == HALTED) & bus.mcu_halt;
        end
    end

    // Halt FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= RUN;
            hcnt <= '0;
        end else begin
            st   <= st_nx;
            hcnt <= hcnt_nx;
        end
    end

    // Halt FSM: drain stalled access, count MCU ticks, then park the MCU
    always_comb begin
        st_nx   = st;
        hcnt_nx = hcnt;
        case (st)
            RUN:    if (bus.mcu_halt & ~halt_l) st_nx = DRAIN;
            DRAIN: begin
                if (!bus.mcu_halt) st_nx = RUN;
                else if (!pend) begin
                    st_nx   = COUNT;
                    hcnt_nx = '0;
                end
            end
            COUNT: begin
                if (!bus.mcu_halt) st_nx = RUN;
                else if (bus.mcu_cen) begin
                    if (hcnt == HCW'(HALTLAT - 1)) st_nx = HALTED;
                    else hcnt_nx = hcnt + 1'b1;
                end
            end
            default: if (!bus.mcu_halt) st_nx = RUN;
        endcase
    end
endmodule
